// File: rtl/jtag_userop_sched.sv
// jtag_userop_sched
// Turns opcodes delivered by a JTAG TAP user register into single bus
// transfers. Keeps a current bus address, four sticky error flags and a
// read/status word handed back to the TAP.
//
// Build option: define JTAG_SCHED_TIMEOUT_EN to abort a bus transfer that
// has gone TIMEOUT cycles without bus_ack. Without it the transfer waits
// for bus_ack indefinitely and the timeout flag reads as 0.
//
// All outputs come straight from registers. trst clears every register
// asynchronously, so bus_req drops the moment reset is applied.

module jtag_userop_sched #(
    parameter int unsigned USERDATA_LEN = 32,
    parameter int unsigned USEROP_LEN   = 8,
    parameter int unsigned ADDR_LEN     = 16,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                    tck,
    input  logic                    trst,
    input  logic                    userOp_ready,
    input  logic [USEROP_LEN-1:0]   userOp,
    input  logic [USERDATA_LEN-1:0] userData_out,
    output logic [USERDATA_LEN-1:0] userData_in,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_LEN-1:0]     bus_addr,
    output logic [USERDATA_LEN-1:0] bus_wdata,
    input  logic                    bus_ack,
    input  logic [USERDATA_LEN-1:0] bus_rdata,
    input  logic                    bus_err,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [USEROP_LEN-1:0] OP_NOP       = USEROP_LEN'(8'h00);
    localparam logic [USEROP_LEN-1:0] OP_SET_ADDR  = USEROP_LEN'(8'h01);
    localparam logic [USEROP_LEN-1:0] OP_WRITE     = USEROP_LEN'(8'h02);
    localparam logic [USEROP_LEN-1:0] OP_WRITE_INC = USEROP_LEN'(8'h03);
    localparam logic [USEROP_LEN-1:0] OP_READ      = USEROP_LEN'(8'h04);
    localparam logic [USEROP_LEN-1:0] OP_READ_INC  = USEROP_LEN'(8'h05);
    localparam logic [USEROP_LEN-1:0] OP_STATUS    = USEROP_LEN'(8'h06);

    // Packs the sticky flags and current address into the TAP status word.
    function automatic logic [USERDATA_LEN-1:0] build_status(
        input logic                err_f,
        input logic                tmo_f,
        input logic                ovr_f,
        input logic                ill_f,
        input logic [ADDR_LEN-1:0] addr_v
    );
        logic [USERDATA_LEN+ADDR_LEN+15:0] word_v;
        word_v                 = '0;
        word_v[0]              = err_f;
        word_v[1]              = tmo_f;
        word_v[2]              = ovr_f;
        word_v[3]              = ill_f;
        word_v[ADDR_LEN+15:16] = addr_v;
        return word_v[USERDATA_LEN-1:0];
    endfunction

    state_t                  state_r, state_s;
    logic                    ready_prev_r;
    logic                    accept_s;
    logic [ADDR_LEN-1:0]     addr_r, addr_s;
    logic                    we_r, we_s;
    logic                    inc_r, inc_s;
    logic                    req_r, req_s;
    logic                    busy_r;
    logic [USERDATA_LEN-1:0] wdata_r, wdata_s;
    logic [USERDATA_LEN-1:0] dout_r, dout_s;
    logic                    flag_err_r, flag_err_s;
    logic                    flag_ovr_r, flag_ovr_s;
    logic                    flag_ill_r, flag_ill_s;
    logic                    set_err_s, set_ovr_s, set_ill_s, clr_flags_s;
    logic                    flag_tmo_view_s;

`ifdef JTAG_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMO_CNT_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic                 flag_tmo_r, flag_tmo_s;
    logic                 set_tmo_s;

    assign flag_tmo_view_s = flag_tmo_r;
`else
    assign flag_tmo_view_s = 1'b0;
`endif

    // A command is taken only on a low-to-high transition of userOp_ready.
    assign accept_s = userOp_ready & ~ready_prev_r;

    // Next-state, bus-control, address and flag logic for the scheduler FSM.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        we_s        = we_r;
        inc_s       = inc_r;
        req_s       = req_r;
        wdata_s     = wdata_r;
        dout_s      = dout_r;
        set_err_s   = 1'b0;
        set_ovr_s   = 1'b0;
        set_ill_s   = 1'b0;
        clr_flags_s = 1'b0;
`ifdef JTAG_SCHED_TIMEOUT_EN
        tmo_cnt_s   = tmo_cnt_r;
        set_tmo_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (userOp)
                        OP_NOP: begin
                            state_s = ST_IDLE;
                        end
                        OP_SET_ADDR: begin
                            addr_s = userData_out[ADDR_LEN-1:0];
                        end
                        OP_WRITE, OP_WRITE_INC: begin
                            state_s = ST_BUS;
                            req_s   = 1'b1;
                            we_s    = 1'b1;
                            wdata_s = userData_out;
                            inc_s   = (userOp == OP_WRITE_INC);
`ifdef JTAG_SCHED_TIMEOUT_EN
                            tmo_cnt_s = '0;
`endif
                        end
                        OP_READ, OP_READ_INC: begin
                            state_s = ST_BUS;
                            req_s   = 1'b1;
                            we_s    = 1'b0;
                            inc_s   = (userOp == OP_READ_INC);
`ifdef JTAG_SCHED_TIMEOUT_EN
                            tmo_cnt_s = '0;
`endif
                        end
                        OP_STATUS: begin
                            dout_s      = build_status(flag_err_r, flag_tmo_view_s,
                                                       flag_ovr_r, flag_ill_r, addr_r);
                            clr_flags_s = 1'b1;
                        end
                        default: begin
                            set_ill_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                // A new command arriving mid-transfer is dropped and flagged.
                if (accept_s) begin
                    set_ovr_s = 1'b1;
                end else begin
                    set_ovr_s = 1'b0;
                end
                if (bus_ack) begin
                    state_s = ST_DONE;
                    req_s   = 1'b0;
                    if (!we_r) begin
                        dout_s = bus_rdata;
                    end else begin
                        dout_s = dout_r;
                    end
                    if (bus_err) begin
                        set_err_s = 1'b1;
                    end else begin
                        set_err_s = 1'b0;
                    end
                    if (inc_r) begin
                        addr_s = addr_r + ADDR_LEN'(1);
                    end else begin
                        addr_s = addr_r;
                    end
`ifdef JTAG_SCHED_TIMEOUT_EN
                end else if (tmo_cnt_r == TMO_CNT_W'(TIMEOUT - 1)) begin
                    // Give up: data and address are left untouched.
                    state_s   = ST_DONE;
                    req_s     = 1'b0;
                    set_tmo_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_CNT_W'(1);
`else
                end else begin
                    state_s = ST_BUS;
`endif
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                if (accept_s) begin
                    set_ovr_s = 1'b1;
                end else begin
                    set_ovr_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
            end
        endcase

        // A flag raised in the same cycle as a STATUS clear stays set.
        flag_err_s = (flag_err_r & ~clr_flags_s) | set_err_s;
        flag_ovr_s = (flag_ovr_r & ~clr_flags_s) | set_ovr_s;
        flag_ill_s = (flag_ill_r & ~clr_flags_s) | set_ill_s;
`ifdef JTAG_SCHED_TIMEOUT_EN
        flag_tmo_s = (flag_tmo_r & ~clr_flags_s) | set_tmo_s;
`endif
    end

    // State, datapath and flag registers; ready_prev resets high so a
    // userOp_ready held high through reset is not taken as a new command.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_r      <= ST_IDLE;
            ready_prev_r <= 1'b1;
            addr_r       <= '0;
            we_r         <= 1'b0;
            inc_r        <= 1'b0;
            req_r        <= 1'b0;
            busy_r       <= 1'b0;
            wdata_r      <= '0;
            dout_r       <= '0;
            flag_err_r   <= 1'b0;
            flag_ovr_r   <= 1'b0;
            flag_ill_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            ready_prev_r <= userOp_ready;
            addr_r       <= addr_s;
            we_r         <= we_s;
            inc_r        <= inc_s;
            req_r        <= req_s;
            busy_r       <= (state_s != ST_IDLE);
            wdata_r      <= wdata_s;
            dout_r       <= dout_s;
            flag_err_r   <= flag_err_s;
            flag_ovr_r   <= flag_ovr_s;
            flag_ill_r   <= flag_ill_s;
        end
    end

`ifdef JTAG_SCHED_TIMEOUT_EN
    // Bus wait counter and sticky timeout flag.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            tmo_cnt_r  <= '0;
            flag_tmo_r <= 1'b0;
        end else begin
            tmo_cnt_r  <= tmo_cnt_s;
            flag_tmo_r <= flag_tmo_s;
        end
    end
`endif

    assign userData_in = dout_r;
    assign bus_req     = req_r;
    assign bus_we      = we_r;
    assign bus_addr    = addr_r;
    assign bus_wdata   = wdata_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_jtag_userop_sched.sv
// Directed bench for jtag_userop_sched: a table of single commands with
// hand-computed results, followed by hand-written multi-cycle sequences
// (overrun, held-high ready, timeout or indefinite wait, reset in BUS).

module tb_jtag_userop_sched;

    logic        tck;
    logic        trst;
    logic        userOp_ready;
    logic [7:0]  userOp;
    logic [31:0] userData_out;
    logic [31:0] userData_in;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        busy;

    int n_vec;
    int n_bad;

    jtag_userop_sched dut (
        .tck          (tck),
        .trst         (trst),
        .userOp_ready (userOp_ready),
        .userOp       (userOp),
        .userData_out (userData_out),
        .userData_in  (userData_in),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err),
        .busy         (busy)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] data;
        logic        is_bus;
        int          dly;
        logic [31:0] rdata;
        logic        err;
        logic [15:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one command with a single-cycle userOp_ready pulse; returns
    // on the falling edge just after the accepting rising edge.
    task automatic send_cmd(input logic [7:0] op, input logic [31:0] d);
        @(negedge tck);
        userOp       = op;
        userData_out = d;
        userOp_ready = 1'b1;
        @(negedge tck);
        userOp_ready = 1'b0;
    endtask

    // Acks a transfer at the current falling edge, then walks through DONE.
    task automatic ack_bus(input logic [31:0] rd, input logic er);
        bus_ack   = 1'b1;
        bus_rdata = rd;
        bus_err   = er;
        @(negedge tck);
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = 32'h0;
        check("req_after_ack", {31'h0, bus_req}, 32'h0);
        check("busy_in_done", {31'h0, busy}, 32'h1);
        @(negedge tck);
    endtask

    initial begin
        int cnt;
        n_vec = 0;
        n_bad = 0;

        //           op     data          bus   dly rdata         err   addr     we    dout
        vecs[0]  = '{8'h01, 32'h0000_1234, 1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h0000_0000};
        vecs[1]  = '{8'h04, 32'h0,         1'b1, 2, 32'hCAFE_F00D, 1'b0, 16'h1234, 1'b0, 32'hCAFE_F00D};
        vecs[2]  = '{8'h06, 32'h0,         1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h1234_0000};
        vecs[3]  = '{8'h01, 32'h0000_FFFF, 1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h1234_0000};
        vecs[4]  = '{8'h03, 32'hA5A5_A5A5, 1'b1, 0, 32'h0,         1'b0, 16'hFFFF, 1'b1, 32'h1234_0000};
        vecs[5]  = '{8'h03, 32'hA5A5_A5A5, 1'b1, 0, 32'h0,         1'b0, 16'h0000, 1'b1, 32'h1234_0000};
        vecs[6]  = '{8'h06, 32'h0,         1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h0001_0000};
        vecs[7]  = '{8'h00, 32'hFFFF_FFFF, 1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h0001_0000};
        vecs[8]  = '{8'h02, 32'h1122_3344, 1'b1, 1, 32'h0,         1'b0, 16'h0001, 1'b1, 32'h0001_0000};
        vecs[9]  = '{8'h05, 32'h0,         1'b1, 0, 32'h0BAD_BEEF, 1'b1, 16'h0001, 1'b0, 32'h0BAD_BEEF};
        vecs[10] = '{8'h06, 32'h0,         1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h0002_0001};
        vecs[11] = '{8'h06, 32'h0,         1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h0002_0000};
        vecs[12] = '{8'h7F, 32'h0,         1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h0002_0000};
        vecs[13] = '{8'h07, 32'h0,         1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h0002_0000};
        vecs[14] = '{8'h06, 32'h0,         1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h0002_0008};
        vecs[15] = '{8'h04, 32'h0,         1'b1, 4, 32'h5A5A_0001, 1'b0, 16'h0002, 1'b0, 32'h5A5A_0001};
        vecs[16] = '{8'h06, 32'h0,         1'b0, 0, 32'h0,         1'b0, 16'h0,    1'b0, 32'h0002_0000};

        trst         = 1'b0;
        userOp_ready = 1'b0;
        userOp       = 8'h0;
        userData_out = 32'h0;
        bus_ack      = 1'b0;
        bus_rdata    = 32'h0;
        bus_err      = 1'b0;

        #12;
        check("rst_dout", userData_in, 32'h0);
        check("rst_req", {31'h0, bus_req}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_addr", {16'h0, bus_addr}, 32'h0);
        check("rst_we", {31'h0, bus_we}, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        @(negedge tck);
        trst = 1'b1;

        // Table of single commands.
        for (int i = 0; i < 17; i++) begin
            send_cmd(vecs[i].op, vecs[i].data);
            if (vecs[i].is_bus) begin
                check($sformatf("v%0d_req_rise", i), {31'h0, bus_req}, 32'h1);
                check($sformatf("v%0d_bus_addr", i), {16'h0, bus_addr}, {16'h0, vecs[i].exp_addr});
                check($sformatf("v%0d_bus_we", i), {31'h0, bus_we}, {31'h0, vecs[i].exp_we});
                if (vecs[i].exp_we) begin
                    check($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].data);
                end
                for (int c = 0; c < vecs[i].dly; c++) begin
                    @(negedge tck);
                    check($sformatf("v%0d_req_hold", i), {15'h0, bus_req, bus_addr},
                          {15'h0, 1'b1, vecs[i].exp_addr});
                end
                ack_bus(vecs[i].rdata, vecs[i].err);
            end
            check($sformatf("v%0d_busy", i), {31'h0, busy}, 32'h0);
            check($sformatf("v%0d_dout", i), userData_in, vecs[i].exp_dout);
        end

        // Held-high userOp_ready: one READ only, no overrun recorded.
        @(negedge tck);
        userOp       = 8'h04;
        userOp_ready = 1'b1;
        @(negedge tck);
        check("hold_req", {31'h0, bus_req}, 32'h1);
        ack_bus(32'h1357_2468, 1'b0);
        repeat (3) @(negedge tck);
        check("hold_no_reaccept", {31'h0, busy}, 32'h0);
        check("hold_dout", userData_in, 32'h1357_2468);
        userOp_ready = 1'b0;
        send_cmd(8'h06, 32'h0);
        check("hold_status", userData_in, 32'h0002_0000);

        // Illegal opcode plus an overrunning command during BUS.
        send_cmd(8'h01, 32'h0);
        send_cmd(8'h7F, 32'h0);
        send_cmd(8'h04, 32'h0);
        check("ovr_req", {31'h0, bus_req}, 32'h1);
        send_cmd(8'h01, 32'h0000_9999);
        check("ovr_req_still", {31'h0, bus_req}, 32'h1);
        check("ovr_addr_kept", {16'h0, bus_addr}, 32'h0);
        ack_bus(32'h2468_1357, 1'b0);
        check("ovr_rdata", userData_in, 32'h2468_1357);
        send_cmd(8'h06, 32'h0);
        check("ovr_status1", userData_in, 32'h0000_000C);
        send_cmd(8'h06, 32'h0);
        check("ovr_status2", userData_in, 32'h0000_0000);

        // Bus never acknowledged.
        send_cmd(8'h01, 32'h0000_00AB);
        send_cmd(8'h04, 32'h0);
        cnt = 0;
`ifdef JTAG_SCHED_TIMEOUT_EN
        for (int c = 0; c < 2000; c++) begin
            if (!bus_req) break;
            cnt++;
            @(negedge tck);
        end
        check("tmo_req_cycles", cnt, 32'd255);
        @(negedge tck);
        check("tmo_busy", {31'h0, busy}, 32'h0);
        check("tmo_dout_kept", userData_in, 32'h0);
        send_cmd(8'h06, 32'h0);
        check("tmo_status", userData_in, 32'h00AB_0002);
`else
        for (int c = 0; c < 1100; c++) begin
            if (!bus_req) break;
            cnt++;
            @(negedge tck);
        end
        check("wait_req_cycles", cnt, 32'd1100);
        ack_bus(32'h0F0F_0F0F, 1'b0);
        send_cmd(8'h06, 32'h0);
        check("wait_status", userData_in, 32'h00AB_0000);
`endif

        // Asynchronous reset in BUS, with userOp_ready high through release.
        send_cmd(8'h04, 32'h0);
        check("rst_bus_req_before", {31'h0, bus_req}, 32'h1);
        #2;
        userOp       = 8'h7F;
        userOp_ready = 1'b1;
        trst         = 1'b0;
        #1;
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_bus_busy", {31'h0, busy}, 32'h0);
        check("rst_bus_dout", userData_in, 32'h0);
        check("rst_bus_addr", {16'h0, bus_addr}, 32'h0);
        @(negedge tck);
        trst = 1'b1;
        repeat (3) @(negedge tck);
        check("rst_hold_idle", {31'h0, busy}, 32'h0);
        userOp_ready = 1'b0;
        send_cmd(8'h06, 32'h0);
        check("rst_status", userData_in, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
